// File: rtl/led7_pkg.sv
// Shared 7-segment code table and decoder state encoding; one table for encoder and decoder.
package led7_pkg;

  // Segment patterns [6:0] = a..g for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h72;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h0D;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [7:0] SEG_FAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_EMIT   = 2'd3
  } led7_state_e;

endpackage

// File: rtl/led7_seg2hex.sv
// Combinational pattern -> nibble lookup; flags blank and unknown patterns.
module led7_seg2hex
  import led7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       err_c,
  output logic       blank_c,
  output logic [3:0] hex_c
);

  // Table lookup; anything outside the table is an error
  always_comb begin
    err_c   = 1'b0;
    blank_c = 1'b0;
    hex_c   = 4'h0;
    case (pattern)
      SEG_0:     hex_c = 4'h0;
      SEG_1:     hex_c = 4'h1;
      SEG_2:     hex_c = 4'h2;
      SEG_3:     hex_c = 4'h3;
      SEG_4:     hex_c = 4'h4;
      SEG_5:     hex_c = 4'h5;
      SEG_6:     hex_c = 4'h6;
      SEG_7:     hex_c = 4'h7;
      SEG_8:     hex_c = 4'h8;
      SEG_9:     hex_c = 4'h9;
      SEG_A:     hex_c = 4'hA;
      SEG_B:     hex_c = 4'hB;
      SEG_C:     hex_c = 4'hC;
      SEG_D:     hex_c = 4'hD;
      SEG_E:     hex_c = 4'hE;
      SEG_F:     hex_c = 4'hF;
      SEG_BLANK: blank_c = 1'b1;
      default:   err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/led7_seg_decode.sv
// Multiplexed 7-segment bus observer: debounces each digit, decodes, and emits change events.
module led7_seg_decode
  import led7_pkg::*;
#(
  parameter  int unsigned NDIG       = 4,
  parameter  int unsigned STABLE_CYC = 3,
  localparam int unsigned IDXW       = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   out_digit,
  output logic [3:0]        out_hex,
  output logic              out_blank,
  output logic              out_err,
  output logic              out_dp,
  output logic [4*NDIG-1:0] hex_flat,
  output logic [NDIG-1:0]   digit_ok,
  output logic              drop_sticky
);

  localparam int unsigned FLW    = $clog2(4*NDIG);
  localparam logic [3:0]  STABLE = 4'(STABLE_CYC);

  led7_state_e       state, state_n;
  logic [7:0]        cap_seg, cap_seg_n;
  logic [NDIG-1:0]   cap_en, cap_en_n;
  logic [3:0]        cnt, cnt_n;
  logic              trk, trk_n;
  logic [7:0]        shadow   [NDIG];
  logic [7:0]        shadow_n [NDIG];

  logic              out_valid_n, out_blank_n, out_err_n, out_dp_n, drop_sticky_n;
  logic [IDXW-1:0]   out_digit_n;
  logic [3:0]        out_hex_n;
  logic [4*NDIG-1:0] hex_flat_n;
  logic [NDIG-1:0]   digit_ok_n;

  logic              onehot_c, same_c, trk_c, done_c, differ_c, handshake_c;
  logic              acc_err_c, acc_blank_c;
  logic [3:0]        acc_hex_c;
  logic [7:0]        step_seg_c, step_shadow_c, acc_shadow_c;
  logic [NDIG-1:0]   step_en_c;
  logic [3:0]        step_cnt_c;
  logic              step_trk_c;
  logic              dec_err_c, dec_blank_c;
  logic [3:0]        dec_hex_c;

  function automatic logic [IDXW-1:0] onehot_idx(input logic [NDIG-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (oh[IDXW'(i)]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  led7_seg2hex u_seg2hex (
    .pattern (cap_seg[6:0]),
    .err_c   (dec_err_c),
    .blank_c (dec_blank_c),
    .hex_c   (dec_hex_c)
  );

  // Next-state, debounce step and output load
  always_comb begin
    state_n       = state;
    cap_seg_n     = cap_seg;
    cap_en_n      = cap_en;
    cnt_n         = cnt;
    trk_n         = trk;
    shadow_n      = shadow;
    out_valid_n   = out_valid;
    out_digit_n   = out_digit;
    out_hex_n     = out_hex;
    out_blank_n   = out_blank;
    out_err_n     = out_err;
    out_dp_n      = out_dp;
    hex_flat_n    = hex_flat;
    digit_ok_n    = digit_ok;
    drop_sticky_n = drop_sticky;

    onehot_c    = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
    same_c      = (seg_in == cap_seg) && (dig_en == cap_en);
    trk_c       = (state == ST_SETTLE) || ((state == ST_EMIT) && trk);
    handshake_c = out_valid && out_ready;

    // One debounce step, shared by SETTLE and the background sampling in EMIT
    step_seg_c = cap_seg;
    step_en_c  = cap_en;
    step_cnt_c = cnt;
    step_trk_c = trk_c;
    if (!onehot_c) begin
      step_cnt_c = 4'd0;
      step_trk_c = 1'b0;
    end else if (trk_c && same_c) begin
      step_cnt_c = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    end else begin
      step_seg_c = seg_in;
      step_en_c  = dig_en;
      step_cnt_c = 4'd1;
      step_trk_c = 1'b1;
    end
    // Fire once on reaching the threshold, not while saturated at it
    done_c = onehot_c && (step_cnt_c == STABLE) && !(trk_c && same_c && (cnt == STABLE));

    step_shadow_c = '0;
    acc_shadow_c  = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (step_en_c[IDXW'(i)]) step_shadow_c = shadow[IDXW'(i)];
      if (cap_en[IDXW'(i)])    acc_shadow_c  = shadow[IDXW'(i)];
    end
    differ_c = (step_seg_c != step_shadow_c);

    acc_err_c   = dec_err_c || (cap_seg == SEG_FAULT);
    acc_blank_c = dec_blank_c && !acc_err_c;
    acc_hex_c   = (acc_err_c || acc_blank_c) ? 4'h0 : dec_hex_c;

    case (state)
      ST_IDLE: begin
        trk_n = 1'b0;
        if (onehot_c) begin
          cap_seg_n = step_seg_c;
          cap_en_n  = step_en_c;
          cnt_n     = step_cnt_c;
          state_n   = done_c ? ST_ACCEPT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cap_seg_n = step_seg_c;
        cap_en_n  = step_en_c;
        cnt_n     = step_cnt_c;
        if (!onehot_c)   state_n = ST_IDLE;
        else if (done_c) state_n = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        trk_n = 1'b0;
        cnt_n = 4'd0;
        if (cap_seg == acc_shadow_c) begin
          state_n = ST_IDLE;
        end else begin
          for (int unsigned i = 0; i < NDIG; i++) begin
            if (cap_en[IDXW'(i)]) begin
              shadow_n[IDXW'(i)]           = cap_seg;
              hex_flat_n[FLW'(4*i) +: 4]   = acc_hex_c;
              digit_ok_n[IDXW'(i)]         = !acc_err_c && !acc_blank_c;
            end
          end
          out_valid_n = 1'b1;
          out_digit_n = onehot_idx(cap_en);
          out_hex_n   = acc_hex_c;
          out_blank_n = acc_blank_c;
          out_err_n   = acc_err_c;
          out_dp_n    = cap_seg[7];
          state_n     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        cap_seg_n = step_seg_c;
        cap_en_n  = step_en_c;
        cnt_n     = step_cnt_c;
        trk_n     = step_trk_c;
        if (handshake_c) begin
          out_valid_n = 1'b0;
          state_n     = done_c ? ST_ACCEPT : ST_IDLE;
        end else if (done_c && differ_c) begin
          drop_sticky_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, debounce, shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cap_seg     <= '0;
      cap_en      <= '0;
      cnt         <= '0;
      trk         <= 1'b0;
      shadow      <= '{default: '0};
      out_valid   <= 1'b0;
      out_digit   <= '0;
      out_hex     <= '0;
      out_blank   <= 1'b0;
      out_err     <= 1'b0;
      out_dp      <= 1'b0;
      hex_flat    <= '0;
      digit_ok    <= '0;
      drop_sticky <= 1'b0;
    end else begin
      state       <= state_n;
      cap_seg     <= cap_seg_n;
      cap_en      <= cap_en_n;
      cnt         <= cnt_n;
      trk         <= trk_n;
      shadow      <= shadow_n;
      out_valid   <= out_valid_n;
      out_digit   <= out_digit_n;
      out_hex     <= out_hex_n;
      out_blank   <= out_blank_n;
      out_err     <= out_err_n;
      out_dp      <= out_dp_n;
      hex_flat    <= hex_flat_n;
      digit_ok    <= digit_ok_n;
      drop_sticky <= drop_sticky_n;
    end
  end

endmodule

// File: tb/tb_led7_seg_decode.sv
// Directed bench for led7_seg_decode with hand-computed expectations.
module tb_led7_seg_decode;

  localparam int unsigned NDIG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        seg_in;
  logic [NDIG-1:0]   dig_en;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_digit;
  logic [3:0]        out_hex;
  logic              out_blank;
  logic              out_err;
  logic              out_dp;
  logic [4*NDIG-1:0] hex_flat;
  logic [NDIG-1:0]   digit_ok;
  logic              drop_sticky;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

  led7_seg_decode #(.NDIG(NDIG), .STABLE_CYC(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_hex     (out_hex),
    .out_blank   (out_blank),
    .out_err     (out_err),
    .out_dp      (out_dp),
    .hex_flat    (hex_flat),
    .digit_ok    (digit_ok),
    .drop_sticky (drop_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for out_valid, sampling on falling edges; lat = falling edges waited
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Count cycles with out_valid high over a window
  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    rst       = 1'b1;
    seg_in    = 8'h00;
    dig_en    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_hex_flat", 32'(hex_flat), 32'd0);
    check("rst_digit_ok", 32'(digit_ok), 32'd0);
    check("rst_drop", 32'(drop_sticky), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First event on digit 0 with pattern 0
    dig_en = 4'b0001;
    seg_in = 8'h7E;
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_digit", 32'(out_digit), 32'd0);
    check("t1_hex", 32'(out_hex), 32'h0);
    check("t1_blank", 32'(out_blank), 32'd0);
    check("t1_err", 32'(out_err), 32'd0);
    check("t1_digit_ok", 32'(digit_ok), 32'b0001);

    // Holding the same byte yields no further event
    count_valid(20, n);
    check("t2_hold_events", 32'(n), 32'd0);
    seg_in = 8'h47;
    wait_valid(lat);
    check("t2_hex", 32'(out_hex), 32'hF);
    count_valid(10, n);
    check("t2_single_event", 32'(n), 32'd0);

    // Glitchy pattern on digit 2 settles to 4
    dig_en = 4'b0100;
    seg_in = 8'h33;
    @(negedge clk);
    seg_in = 8'h30;
    @(negedge clk);
    seg_in = 8'h33;
    wait_valid(lat);
    check("t3_latency", 32'(lat), 32'd4);
    check("t3_digit", 32'(out_digit), 32'd2);
    check("t3_hex", 32'(out_hex), 32'h4);
    check("t3_hex_flat", 32'(hex_flat), 32'h040F);
    count_valid(10, n);
    check("t3_single_event", 32'(n), 32'd0);

    // Fault marker, blank, and decimal point on digit 1
    dig_en = 4'b0010;
    seg_in = 8'hFF;
    wait_valid(lat);
    check("t4_err", 32'(out_err), 32'd1);
    check("t4_err_hex", 32'(out_hex), 32'h0);
    check("t4_err_digit", 32'(out_digit), 32'd1);
    check("t4_err_ok", 32'(digit_ok), 32'b0101);
    seg_in = 8'h00;
    wait_valid(lat);
    check("t4_blank", 32'(out_blank), 32'd1);
    check("t4_blank_err", 32'(out_err), 32'd0);
    check("t4_blank_ok", 32'(digit_ok), 32'b0101);
    seg_in = 8'hB0;
    wait_valid(lat);
    check("t4_dp", 32'(out_dp), 32'd1);
    check("t4_dp_hex", 32'(out_hex), 32'h1);
    check("t4_dp_ok", 32'(digit_ok), 32'b0111);

    // Every code of the table, rotating over all digits
    for (int i = 0; i < 16; i++) begin
      dig_en = NDIG'(1) << (i % 4);
      seg_in = {1'b0, codes[i]};
      wait_valid(lat);
      check($sformatf("tab%0d_hex", i), 32'(out_hex), 32'(i));
      check($sformatf("tab%0d_digit", i), 32'(out_digit), 32'(i % 4));
      check($sformatf("tab%0d_flags", i), {30'd0, out_err, out_blank}, 32'd0);
    end
    check("tab_hex_flat", 32'(hex_flat), 32'hFEDC);
    check("tab_drop", 32'(drop_sticky), 32'd0);

    // Stalled consumer: second change is dropped, first event held
    dig_en = '0;
    @(negedge clk);
    out_ready = 1'b0;
    dig_en = 4'b1000;
    seg_in = 8'h77;
    wait_valid(lat);
    check("t5_hex", 32'(out_hex), 32'hA);
    dig_en = 4'b0001;
    seg_in = 8'h1F;
    repeat (6) @(negedge clk);
    check("t5_drop", 32'(drop_sticky), 32'd1);
    check("t5_valid_held", 32'(out_valid), 32'd1);
    check("t5_hex_held", 32'(out_hex), 32'hA);
    check("t5_digit_held", 32'(out_digit), 32'd3);
    check("t5_hex_flat", 32'(hex_flat), 32'hAEDC);
    out_ready = 1'b1;
    dig_en = '0;
    @(negedge clk);
    check("t5_released", 32'(out_valid), 32'd0);
    check("t5_no_update", 32'(hex_flat), 32'hAEDC);
    check("t5_drop_stays", 32'(drop_sticky), 32'd1);

    // Reset while an event is pending
    out_ready = 1'b0;
    dig_en = 4'b0100;
    seg_in = 8'h5B;
    wait_valid(lat);
    check("t6_hex", 32'(out_hex), 32'h5);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_hex_flat", 32'(hex_flat), 32'd0);
    check("t6_digit_ok", 32'(digit_ok), 32'd0);
    check("t6_drop", 32'(drop_sticky), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
